multiword_add_seq: RTL

//   Multi-cycle sequencer for wide add/subtract on one shared SIZE-bit ripple adder (adder_p).

---
 rtl/multiword_add_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequencer built around one shared SIZE-bit ripple adder.
// Operands are processed one word per cycle, least significant word first.

module adder_p #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] sum,
    output logic            cout
);

    logic [SIZE:0] c;

    // Explicit bit-level ripple chain, so the critical path is visibly SIZE full adders.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < SIZE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SIZE];
    end

endmodule

module multiword_add_seq #(
    parameter int SIZE  = 32,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE*WORDS-1:0] in_a,
    input  logic [SIZE*WORDS-1:0] in_b,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE*WORDS-1:0] out_sum,
    output logic                  out_carry
);

    localparam int IDXW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   idx;
    logic              carry_q;
    logic              sub_q;
    logic [SIZE-1:0]   a_words   [WORDS];
    logic [SIZE-1:0]   b_words   [WORDS];
    logic [SIZE-1:0]   sum_words [WORDS];
    logic [SIZE-1:0]   add_b;
    logic [SIZE-1:0]   add_sum;
    logic              add_cout;
    logic              last_word;

    // Subtraction is A + ~B + 1; the +1 comes from seeding the carry register with in_sub.
    assign add_b     = sub_q ? ~b_words[idx] : b_words[idx];
    assign last_word = (idx == IDXW'(WORDS - 1));

    adder_p #(.SIZE(SIZE)) u_adder (
        .a    (a_words[idx]),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            out_carry <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                a_words[i]   <= '0;
                b_words[i]   <= '0;
                sum_words[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx     <= '0;
                        carry_q <= in_sub;
                        sub_q   <= in_sub;
                        for (int i = 0; i < WORDS; i++) begin
                            a_words[i] <= in_a[i*SIZE +: SIZE];
                            b_words[i] <= in_b[i*SIZE +: SIZE];
                        end
                    end
                end
                RUN: begin
                    sum_words[idx] <= add_sum;
                    carry_q        <= add_cout;
                    // idx parks on the last word rather than wrapping.
                    if (last_word) out_carry <= add_cout;
                    else           idx       <= idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_sum = '0;
        for (int i = 0; i < WORDS; i++) out_sum[i*SIZE +: SIZE] = sum_words[i];
    end

endmodule
